fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter N, default 32: address and instruction width.
REQ-002 Parameter RESET_PC, default 32'h0040_0000: PC loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard-unit hold request; when 1, the PC and the IF/ID-facing outputs hold their values.
REQ-006 redirect  input  1  taken branch/jump from a later stage; takes priority over stall.
REQ-007 redirect_pc  input  N  target address, valid when redirect=1.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  N  read address, equal to the internal PC register.
REQ-010 imem_ready  input  1  memory response; imem_rdata is valid for imem_addr in the same cycle.
REQ-011 imem_rdata  input  N  instruction word.
REQ-012 PC_4  output  N  registered PC+4 of the delivered instruction, feeding the IF/ID register.
REQ-013 Instruction  output  N  registered instruction, or 0 (NOP) for a bubble.
REQ-014 valid  output  1  1 when Instruction is a real fetched word, 0 for a bubble.

Function
REQ-015 The block SHALL have two states: FETCH (imem_req=1) and HOLD (imem_req=0, one fetched word buffered in a skid register).
REQ-016 imem_addr SHALL change only on an accepted fetch or on a redirect; it stays stable while imem_req=1 and imem_ready=0.
REQ-017 FETCH, imem_ready=1, stall=0, redirect=0: next edge Instruction<=imem_rdata, PC_4<=PC+4, valid<=1, PC<=PC+4; stay in FETCH.
REQ-018 FETCH, imem_ready=1, stall=1, redirect=0: the skid register captures imem_rdata; PC<=PC+4; outputs hold; go to HOLD.
REQ-019 FETCH, imem_ready=0, stall=0, redirect=0: the outputs become a bubble (Instruction=0, valid=0); PC_4 holds.
REQ-020 FETCH, imem_ready=0, stall=1: PC and outputs hold.
REQ-021 HOLD, stall=1: everything holds and no new request is issued.
REQ-022 HOLD, stall=0: the outputs load the skid word with its PC+4, valid<=1; go to FETCH at the already-advanced PC.
REQ-023 On redirect=1 in any state: PC<={redirect_pc[N-1:2],2'b00}; the outputs become a bubble; any same-cycle imem response and any skid word are discarded; go to FETCH.
REQ-024 In the cycle redirect=1, imem_req SHALL be 0.
REQ-025 PC+4 SHALL wrap modulo 2^N (for example, 32'hFFFF_FFFC+4=0) with no flag.
REQ-026 Latency: a word accepted at edge k appears on Instruction/valid after edge k; it is never delivered twice and never dropped, except by redirect or reset.
REQ-027 The outputs SHALL never change while stall=1 and redirect=0, because the downstream IF/ID register has no enable.

Reset
REQ-028 When reset=1 at an edge: PC<=RESET_PC, state<=FETCH, Instruction<=0, PC_4<=0, valid<=0, skid register cleared.
REQ-029 reset SHALL override redirect, stall and imem_ready, and it discards any in-flight response.
REQ-030 While reset=1, imem_req SHALL be 0; in the first cycle after release, imem_req=1 with imem_addr=RESET_PC.

Verification
REQ-031 Release reset with imem_ready=1 and rdata=0x2008_0005: imem_addr=0x0040_0000; one cycle later Instruction=0x2008_0005, PC_4=0x0040_0004, valid=1.
REQ-032 Hold imem_ready=0 for 3 cycles at PC 0x0040_0008: address is stable, valid=0, Instruction=0 for those cycles; the word is delivered on the cycle after ready.
REQ-033 Assert stall in the same cycle as ready (rdata=0xAAAA_0001) and keep it for 2 cycles: outputs unchanged and imem_req=0 in HOLD; after stall drops, Instruction=0xAAAA_0001, valid=1, delivered exactly once.
REQ-034 In HOLD, apply redirect with redirect_pc=0x0040_0103: skid word is discarded, a bubble is output, and the next imem_addr=0x0040_0100.
REQ-035 Apply redirect and stall together with ready=1: redirect wins, the response is ignored, and the outputs are a bubble.
REQ-036 Set PC=0xFFFF_FFFC via redirect and accept one fetch: PC_4=0x0000_0000 and the next imem_addr=0.

Source files
------------

// File: rtl/imem_if.sv
// Instruction-memory request/response bundle.
// master = fetch side, slave = memory side.
interface imem_if #(
  parameter int N = 32
);
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_ready;
  logic [N-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem handshake and a one-word
// skid buffer so a stalled IF/ID register never loses a response.
module fetch_unit #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = N'(32'h0040_0000)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  imem_if.master       imem,
  output logic [N-1:0] PC_4,
  output logic [N-1:0] Instruction,
  output logic         valid
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t       state_q;
  logic [N-1:0] pc_q;
  logic [N-1:0] pc4_q;
  logic [N-1:0] ins_q;
  logic         val_q;
  logic [N-1:0] skid_q;
  logic [N-1:0] pc_plus4;

  assign pc_plus4 = pc_q + N'(4);

  // Request drops combinationally so a redirect never fetches a stale PC.
  assign imem.imem_req  = (state_q == FETCH) && !redirect && !reset;
  assign imem.imem_addr = pc_q;

  assign PC_4        = pc4_q;
  assign Instruction = ins_q;
  assign valid       = val_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      pc4_q   <= '0;
      ins_q   <= '0;
      val_q   <= 1'b0;
      skid_q  <= '0;
    end else if (redirect) begin
      state_q <= FETCH;
      pc_q    <= {redirect_pc[N-1:2], 2'b00};
      ins_q   <= '0;
      val_q   <= 1'b0;
      skid_q  <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem.imem_ready) begin
            pc_q <= pc_plus4;
            if (stall) begin
              skid_q  <= imem.imem_rdata;
              state_q <= HOLD;
            end else begin
              ins_q <= imem.imem_rdata;
              pc4_q <= pc_plus4;
              val_q <= 1'b1;
            end
          end else if (!stall) begin
            ins_q <= '0;
            val_q <= 1'b0;
          end
        end
        HOLD: begin
          // pc_q already points past the buffered word.
          if (!stall) begin
            ins_q   <= skid_q;
            pc4_q   <= pc_q;
            val_q   <= 1'b1;
            skid_q  <= '0;
            state_q <= FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a
// transaction-level model (accepted-word queue, expected PC).
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] PC_4;
  logic [31:0] Instruction;
  logic        valid;

  imem_if #(.N(32)) bus ();

  fetch_unit #(.N(32), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus.master),
    .PC_4        (PC_4),
    .Instruction (Instruction),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [31:0] p4;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mpc = RPC;
  logic [31:0] e_ins = '0;
  logic [31:0] e_pc4 = '0;
  logic        e_val = 1'b0;
  logic        obs_req, exp_req;
  logic [31:0] obs_addr, exp_addr;
  int          checks = 0;
  int          errors = 0;

  // One clock: drive at negedge, sample request, advance model at posedge.
  task automatic cycle(input logic r, input logic s, input logic rd,
                       input logic [31:0] rpc, input logic rdy,
                       input logic [31:0] rdat);
    ent_t e;
    @(negedge clk);
    reset = r; stall = s; redirect = rd; redirect_pc = rpc;
    bus.imem_ready = rdy; bus.imem_rdata = rdat;
    #1;
    obs_req  = bus.imem_req;
    obs_addr = bus.imem_addr;
    exp_req  = !r && !rd && (q.size() == 0);
    exp_addr = mpc;
    @(posedge clk);
    if (r) begin
      mpc = RPC; q.delete(); e_ins = '0; e_pc4 = '0; e_val = 1'b0;
    end else if (rd) begin
      mpc = {rpc[31:2], 2'b00}; q.delete(); e_ins = '0; e_val = 1'b0;
    end else begin
      if (exp_req && rdy) begin
        q.push_back('{w: rdat, p4: mpc + 32'd4});
        mpc = mpc + 32'd4;
      end
      if (!s) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          e_ins = e.w; e_pc4 = e.p4; e_val = 1'b1;
        end else begin
          e_ins = '0; e_val = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 1, 32'h1234_5678, 1, 32'hDEAD_BEEF);
    cycle(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checks++;
    if (obs_req !== 1'b0) begin
      errors++; $display("FAIL rst_req got %0b want 0", obs_req);
    end
    checks++;
    if ({Instruction, PC_4, valid} !== 65'd0) begin
      errors++;
      $display("FAIL rst_out got %h/%h/%0b want 0/0/0", Instruction, PC_4, valid);
    end
    cycle(0, 0, 0, 0, 1, 32'h2008_0005);
    checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h0040_0000) begin
      errors++; $display("FAIL rel_addr got %0b/%h want 1/00400000", obs_req, obs_addr);
    end
    checks++;
    if (Instruction !== 32'h2008_0005 || PC_4 !== 32'h0040_0004 || valid !== 1'b1) begin
      errors++;
      $display("FAIL first_word got %h/%h/%0b want 20080005/00400004/1",
               Instruction, PC_4, valid);
    end
  endtask

  task automatic test_wait_ready();
    cycle(0, 0, 0, 0, 1, 32'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 32'hBAD0_0000 + i);
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== 32'h0040_0008) begin
        errors++; $display("FAIL wait_addr got %0b/%h want 1/00400008", obs_req, obs_addr);
      end
      checks++;
      if (valid !== 1'b0 || Instruction !== 32'd0) begin
        errors++; $display("FAIL wait_bubble got %h/%0b want 0/0", Instruction, valid);
      end
    end
    cycle(0, 0, 0, 0, 1, 32'h3333_3333);
    checks++;
    if (Instruction !== 32'h3333_3333 || PC_4 !== 32'h0040_000C || valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_deliver got %h/%h/%0b want 33333333/0040000c/1",
               Instruction, PC_4, valid);
    end
  endtask

  task automatic test_stall_skid();
    cycle(0, 1, 0, 0, 1, 32'hAAAA_0001);
    checks++;
    if (Instruction !== 32'h3333_3333 || valid !== 1'b1 || PC_4 !== 32'h0040_000C) begin
      errors++; $display("FAIL skid_hold1 got %h/%0b want 33333333/1", Instruction, valid);
    end
    cycle(0, 1, 0, 0, 1, 32'hBBBB_0002);
    checks++;
    if (obs_req !== 1'b0) begin
      errors++; $display("FAIL skid_req got %0b want 0", obs_req);
    end
    checks++;
    if (Instruction !== 32'h3333_3333 || valid !== 1'b1) begin
      errors++; $display("FAIL skid_hold2 got %h/%0b want 33333333/1", Instruction, valid);
    end
    cycle(0, 0, 0, 0, 1, 32'hCCCC_0003);
    checks++;
    if (Instruction !== 32'hAAAA_0001 || PC_4 !== 32'h0040_0010 || valid !== 1'b1) begin
      errors++;
      $display("FAIL skid_out got %h/%h/%0b want aaaa0001/00400010/1",
               Instruction, PC_4, valid);
    end
    cycle(0, 0, 0, 0, 0, 32'hDDDD_0004);
    checks++;
    if (valid !== 1'b0 || obs_addr !== 32'h0040_0010) begin
      errors++; $display("FAIL skid_once got %0b/%h want 0/00400010", valid, obs_addr);
    end
  endtask

  task automatic test_redirect_hold();
    cycle(0, 1, 0, 0, 1, 32'h5555_0005);
    cycle(0, 1, 1, 32'h0040_0103, 1, 32'h6666_0006);
    checks++;
    if (obs_req !== 1'b0) begin
      errors++; $display("FAIL rdr_req got %0b want 0", obs_req);
    end
    checks++;
    if (valid !== 1'b0 || Instruction !== 32'd0) begin
      errors++; $display("FAIL rdr_bubble got %h/%0b want 0/0", Instruction, valid);
    end
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h0040_0100 || valid !== 1'b0) begin
      errors++;
      $display("FAIL rdr_addr got %0b/%h/%0b want 1/00400100/0", obs_req, obs_addr, valid);
    end
  endtask

  task automatic test_redirect_stall();
    cycle(0, 0, 0, 0, 1, 32'h7777_0007);
    cycle(0, 1, 1, 32'h0040_0200, 1, 32'h8888_0008);
    checks++;
    if (valid !== 1'b0 || Instruction !== 32'd0) begin
      errors++; $display("FAIL rdr_stall got %h/%0b want 0/0", Instruction, valid);
    end
    cycle(0, 0, 0, 0, 1, 32'h9999_0009);
    checks++;
    if (obs_addr !== 32'h0040_0200 || Instruction !== 32'h9999_0009 || valid !== 1'b1) begin
      errors++;
      $display("FAIL rdr_stall_next got %h/%h/%0b want 00400200/99990009/1",
               obs_addr, Instruction, valid);
    end
  endtask

  task automatic test_wrap();
    cycle(0, 0, 1, 32'hFFFF_FFFE, 1, 32'h1234_0000);
    cycle(0, 0, 0, 0, 1, 32'hCAFE_F00D);
    checks++;
    if (obs_addr !== 32'hFFFF_FFFC || PC_4 !== 32'd0 || Instruction !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL wrap got %h/%h/%h want fffffffc/0/cafef00d", obs_addr, PC_4, Instruction);
    end
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs_addr !== 32'd0 || obs_req !== 1'b1) begin
      errors++; $display("FAIL wrap_addr got %h/%0b want 0/1", obs_addr, obs_req);
    end
  endtask

  task automatic test_random();
    logic        r, s, rd, rdy;
    logic [31:0] rpc;
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(99) < 2);
      rd  = ($urandom_range(99) < 8);
      s   = ($urandom_range(99) < 40);
      rdy = ($urandom_range(99) < 70);
      rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(15))
                                     : $urandom;
      cycle(r, s, rd, rpc, rdy, $urandom);
      checks++;
      if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin
        errors++;
        $display("FAIL rnd_req cyc %0d got %0b/%h want %0b/%h",
                 i, obs_req, obs_addr, exp_req, exp_addr);
      end
      checks++;
      if (Instruction !== e_ins || PC_4 !== e_pc4 || valid !== e_val) begin
        errors++;
        $display("FAIL rnd_out cyc %0d got %h/%h/%0b want %h/%h/%0b",
                 i, Instruction, PC_4, valid, e_ins, e_pc4, e_val);
      end
    end
  endtask

  initial begin
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    test_reset();
    test_wait_ready();
    test_stall_skid();
    test_redirect_hold();
    test_redirect_stall();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
